graph_edge_server: RTL and testbench

Responder side of the accelerator's node-fetch interface: holds the graph adjacency in on-chip memory and answers node-index requests with that node's successor indices, one per beat, each tagged with a remaining-edge count. It is loaded over a simple command stream and sits between the host loader and the path-counting core. After loading, it first presents the start node, then the end node, then serves requests.

---
 rtl/graph_pkg.sv | 26 ++
 rtl/graph_edge_mem.sv | 33 +++
 rtl/graph_edge_server.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_graph_edge_server.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// graph_pkg: shared definitions for the graph edge server and the
// path-counting core.
//   - default width constants for node index, edge counter and edge storage
//   - load command encodings
//   - edge server state enum
package graph_pkg;

    localparam int DEF_NODE_IDX_WIDTH = 10;
    localparam int DEF_COUNTER_WIDTH  = 4;
    localparam int DEF_EDGE_MEM_DEPTH = 2048;

    localparam logic [1:0] CMD_EDGE      = 2'b00;
    localparam logic [1:0] CMD_SET_START = 2'b01;
    localparam logic [1:0] CMD_SET_END   = 2'b10;
    localparam logic [1:0] CMD_DONE      = 2'b11;

    typedef enum logic [2:0] {
        ST_LOAD       = 3'd0,
        ST_SEND_START = 3'd1,
        ST_SEND_END   = 3'd2,
        ST_IDLE       = 3'd3,
        ST_LOOKUP     = 3'd4,
        ST_STREAM     = 3'd5
    } state_t;

endpackage

// File: rtl/graph_edge_mem.sv
// graph_edge_mem: simple dual-port edge storage, synchronous read,
// shaped for block-RAM inference. No reset; contents are undefined
// until written.
// Ports:
//   clk      rising-edge clock
//   wr_en    write enable (load side)
//   wr_addr  write address
//   wr_data  write data (destination node index)
//   rd_addr  read address (stream side), sampled every cycle
//   rd_data  registered read data, valid the cycle after rd_addr
module graph_edge_mem #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/graph_edge_server.sv
// graph_edge_server: responder side of the node-fetch interface.
// Holds the graph adjacency (node table + edge memory), is loaded over a
// command stream, presents start then end node, then answers node requests
// with one successor per beat tagged with the remaining-edge count.
//
// Build option: EDGE_SERVER_ERR_CHECK_EN
//   defined   - order / fan-out / overflow checks present, err_* sticky flags
//   undefined - checks removed, err_* tied 0, write pointer and fan-out
//               count wrap, non-contiguous edges overwrite the node base
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   reload                    sync return to LOAD, clears node-seen bits
//   load_valid/ready/cmd/src/dst   load command stream
//   req_valid/ready/node_idx  node request
//   rsp_valid/ready           response beat handshake
//   next_node_idx/counter     beat payload: node index, edges remaining
//   err_overflow/fanout/order sticky load error flags
//
// state      | meaning
// -----------+---------------------------------------------
// LOAD       | accepting load commands
// SEND_START | presenting start node (counter 1)
// SEND_END   | presenting end node (counter 1)
// IDLE       | waiting for a node request
// LOOKUP     | node table read, first edge read issued
// STREAM     | one successor per beat, prefetching the next
module graph_edge_server
    import graph_pkg::*;
#(
    parameter int NODE_IDX_WIDTH = DEF_NODE_IDX_WIDTH,
    parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
    parameter int EDGE_MEM_DEPTH = DEF_EDGE_MEM_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reload,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [1:0]                load_cmd,
    input  logic [NODE_IDX_WIDTH-1:0] load_src,
    input  logic [NODE_IDX_WIDTH-1:0] load_dst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [NODE_IDX_WIDTH-1:0] req_node_idx,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [NODE_IDX_WIDTH-1:0] next_node_idx,
    output logic [COUNTER_WIDTH-1:0]  next_node_counter,
    output logic                      err_overflow,
    output logic                      err_fanout,
    output logic                      err_order
);

    localparam int EDGE_ADDR_WIDTH = $clog2(EDGE_MEM_DEPTH);
    localparam int NODE_COUNT      = 1 << NODE_IDX_WIDTH;
`ifdef EDGE_SERVER_ERR_CHECK_EN
    // One extra bit so a full memory (wr_ptr == depth) is distinguishable.
    localparam int PTR_WIDTH = EDGE_ADDR_WIDTH + 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
`else
    localparam int PTR_WIDTH = EDGE_ADDR_WIDTH;
`endif

    state_t state, state_next;

    logic [EDGE_ADDR_WIDTH-1:0] node_base [NODE_COUNT];
    logic [COUNTER_WIDTH-1:0]   node_cnt  [NODE_COUNT];
    logic [NODE_COUNT-1:0]      seen;

    logic [PTR_WIDTH-1:0]       wr_ptr;
    logic [EDGE_ADDR_WIDTH-1:0] wr_addr;
    logic [NODE_IDX_WIDTH-1:0]  last_src;
    logic                       last_valid;
    logic [NODE_IDX_WIDTH-1:0]  start_q;
    logic [NODE_IDX_WIDTH-1:0]  end_q;

    logic [NODE_IDX_WIDTH-1:0]  req_idx_q;
    logic [EDGE_ADDR_WIDTH-1:0] base_q;
    logic [COUNTER_WIDTH-1:0]   cnt_q;
    logic [COUNTER_WIDTH-1:0]   k_q;
    logic                       empty_q;
    logic [COUNTER_WIDTH-1:0]   stream_counter;

    logic [EDGE_ADDR_WIDTH-1:0] rd_addr;
    logic [NODE_IDX_WIDTH-1:0]  rd_data;

    logic load_fire;
    logic edge_fire;
    logic edge_accept;
    logic new_src;
    logic rsp_fire;

    assign load_fire = load_valid && (state == ST_LOAD) && !reload;
    assign edge_fire = load_fire && (load_cmd == CMD_EDGE);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign wr_addr   = wr_ptr[EDGE_ADDR_WIDTH-1:0];

    // last_valid keeps the very first edge (or first after reload) from
    // being mistaken for a continuation of node 0.
    assign new_src = !last_valid || (load_src != last_src);

`ifdef EDGE_SERVER_ERR_CHECK_EN
    logic drop_order;
    logic drop_fanout;
    logic drop_overflow;
    logic err_order_q;
    logic err_fanout_q;
    logic err_overflow_q;

    always_comb begin
        drop_order    = new_src && seen[load_src];
        drop_fanout   = !new_src && (node_cnt[load_src] == CNT_MAX);
        drop_overflow = (wr_ptr == PTR_WIDTH'(EDGE_MEM_DEPTH));
    end

    assign edge_accept = edge_fire && !drop_order && !drop_fanout && !drop_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_order_q    <= 1'b0;
            err_fanout_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else if (edge_fire) begin
            if (drop_order)    err_order_q    <= 1'b1;
            if (drop_fanout)   err_fanout_q   <= 1'b1;
            if (drop_overflow) err_overflow_q <= 1'b1;
        end
    end

    assign err_order    = err_order_q;
    assign err_fanout   = err_fanout_q;
    assign err_overflow = err_overflow_q;
`else
    assign edge_accept  = edge_fire;
    assign err_order    = 1'b0;
    assign err_fanout   = 1'b0;
    assign err_overflow = 1'b0;
`endif

    // Load-side control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            seen       <= '0;
            last_src   <= '0;
            last_valid <= 1'b0;
            start_q    <= '0;
            end_q      <= '0;
        end else if (reload) begin
            seen       <= '0;
            last_valid <= 1'b0;
        end else if (load_fire) begin
            case (load_cmd)
                CMD_EDGE: begin
                    if (edge_accept) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        last_src   <= load_src;
                        last_valid <= 1'b1;
                        if (new_src) seen[load_src] <= 1'b1;
                    end
                end
                CMD_SET_START: start_q <= load_dst;
                CMD_SET_END:   end_q   <= load_dst;
                default: ;
            endcase
        end
    end

    // Node table: read-modify-write in the same cycle, so back-to-back
    // edges from one source need no bubble.
    always_ff @(posedge clk) begin
        if (edge_accept) begin
            if (new_src) begin
                node_base[load_src] <= wr_addr;
                node_cnt[load_src]  <= COUNTER_WIDTH'(1);
            end else begin
                node_cnt[load_src]  <= node_cnt[load_src] + 1'b1;
            end
        end
    end

    graph_edge_mem #(
        .DATA_WIDTH (NODE_IDX_WIDTH),
        .DEPTH      (EDGE_MEM_DEPTH),
        .ADDR_WIDTH (EDGE_ADDR_WIDTH)
    ) u_edge_mem (
        .clk     (clk),
        .wr_en   (edge_accept),
        .wr_addr (wr_addr),
        .wr_data (load_dst),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Request-side registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_idx_q <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            empty_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                req_idx_q <= req_node_idx;
            end
            if (state == ST_LOOKUP) begin
                base_q  <= node_base[req_idx_q];
                cnt_q   <= node_cnt[req_idx_q];
                k_q     <= '0;
                empty_q <= !seen[req_idx_q] || (node_cnt[req_idx_q] == '0);
            end else if (state == ST_STREAM && rsp_fire) begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    assign stream_counter = cnt_q - k_q;

    // The RAM is read every cycle. While streaming, the address already
    // includes this cycle's acceptance, so rd_data always holds entry k and
    // a stalled beat keeps its data.
    always_comb begin
        if (state == ST_STREAM) begin
            rd_addr = base_q + EDGE_ADDR_WIDTH'(k_q) + EDGE_ADDR_WIDTH'(rsp_fire);
        end else begin
            rd_addr = node_base[req_idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (reload) begin
            state_next = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:       if (load_valid && load_cmd == CMD_DONE) state_next = ST_SEND_START;
                ST_SEND_START: if (rsp_ready) state_next = ST_SEND_END;
                ST_SEND_END:   if (rsp_ready) state_next = ST_IDLE;
                ST_IDLE:       if (req_valid) state_next = ST_LOOKUP;
                ST_LOOKUP:     state_next = ST_STREAM;
                ST_STREAM: begin
                    if (rsp_ready && (empty_q || stream_counter == COUNTER_WIDTH'(1))) begin
                        state_next = ST_IDLE;
                    end
                end
                default:       state_next = ST_LOAD;
            endcase
        end
    end

    always_comb begin
        load_ready        = 1'b0;
        req_ready         = 1'b0;
        rsp_valid         = 1'b0;
        next_node_idx     = '0;
        next_node_counter = '0;
        case (state)
            ST_LOAD: load_ready = 1'b1;
            ST_SEND_START: begin
                rsp_valid         = 1'b1;
                next_node_idx     = start_q;
                next_node_counter = COUNTER_WIDTH'(1);
            end
            ST_SEND_END: begin
                rsp_valid         = 1'b1;
                next_node_idx     = end_q;
                next_node_counter = COUNTER_WIDTH'(1);
            end
            ST_IDLE: req_ready = 1'b1;
            ST_STREAM: begin
                rsp_valid = 1'b1;
                if (!empty_q) begin
                    next_node_idx     = rd_data;
                    next_node_counter = stream_counter;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_graph_edge_server.sv
module tb_graph_edge_server;
    import graph_pkg::*;

`ifdef EDGE_SERVER_ERR_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-size instance
    logic       rst, reload, load_valid, load_ready;
    logic [1:0] load_cmd;
    logic [9:0] load_src, load_dst;
    logic       req_valid, req_ready;
    logic [9:0] req_node_idx;
    logic       rsp_valid, rsp_ready;
    logic [9:0] next_node_idx;
    logic [3:0] next_node_counter;
    logic       err_overflow, err_fanout, err_order;

    // Small instance: depth 4, 2-bit counter, 16 nodes
    logic       s_rst, s_reload, s_load_valid, s_load_ready;
    logic [1:0] s_load_cmd;
    logic [3:0] s_load_src, s_load_dst;
    logic       s_req_valid, s_req_ready;
    logic [3:0] s_req_node_idx;
    logic       s_rsp_valid, s_rsp_ready;
    logic [3:0] s_next_node_idx;
    logic [1:0] s_next_node_counter;
    logic       s_err_overflow, s_err_fanout, s_err_order;

    graph_edge_server dut (
        .clk(clk), .rst(rst), .reload(reload),
        .load_valid(load_valid), .load_ready(load_ready), .load_cmd(load_cmd),
        .load_src(load_src), .load_dst(load_dst),
        .req_valid(req_valid), .req_ready(req_ready), .req_node_idx(req_node_idx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .next_node_idx(next_node_idx), .next_node_counter(next_node_counter),
        .err_overflow(err_overflow), .err_fanout(err_fanout), .err_order(err_order)
    );

    graph_edge_server #(.NODE_IDX_WIDTH(4), .COUNTER_WIDTH(2), .EDGE_MEM_DEPTH(4)) dut_s (
        .clk(clk), .rst(s_rst), .reload(s_reload),
        .load_valid(s_load_valid), .load_ready(s_load_ready), .load_cmd(s_load_cmd),
        .load_src(s_load_src), .load_dst(s_load_dst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_node_idx(s_req_node_idx),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .next_node_idx(s_next_node_idx), .next_node_counter(s_next_node_counter),
        .err_overflow(s_err_overflow), .err_fanout(s_err_fanout), .err_order(s_err_order)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [9:0]      node;
        logic [3:0]      n;
        logic [2:0][9:0] idx;
        logic [2:0][3:0] cnt;
    } vec_t;

    vec_t vecs [6];

    logic [9:0] got_idx [16];
    logic [3:0] got_cnt [16];
    int         got_n;
    logic [3:0] s_got_idx [8];
    logic [1:0] s_got_cnt [8];
    int         s_got_n;

    function automatic vec_t mk(int node, int n, int i0, int c0, int i1, int c1, int i2, int c2);
        vec_t v;
        v.node   = 10'(node);
        v.n      = 4'(n);
        v.idx[0] = 10'(i0);
        v.cnt[0] = 4'(c0);
        v.idx[1] = 10'(i1);
        v.cnt[1] = 4'(c1);
        v.idx[2] = 10'(i2);
        v.cnt[2] = 4'(c2);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [1:0] cmd, input int src, input int dst);
        load_valid = 1'b1;
        load_cmd   = cmd;
        load_src   = 10'(src);
        load_dst   = 10'(dst);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic s_load(input logic [1:0] cmd, input int src, input int dst);
        s_load_valid = 1'b1;
        s_load_cmd   = cmd;
        s_load_src   = 4'(src);
        s_load_dst   = 4'(dst);
        @(negedge clk);
        s_load_valid = 1'b0;
    endtask

    // Issue a request from IDLE and record beats until the last one is taken.
    task automatic request(input int node);
        bit done;
        done         = 1'b0;
        req_valid    = 1'b1;
        req_node_idx = 10'(node);
        rsp_ready    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        got_n     = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (rsp_valid && got_n < 16) begin
                got_idx[got_n] = next_node_idx;
                got_cnt[got_n] = next_node_counter;
                got_n++;
                if (next_node_counter <= 4'd1) done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL request_%0d: last beat not seen within budget", node);
        end
    endtask

    task automatic s_request(input int node);
        bit done;
        done           = 1'b0;
        s_req_valid    = 1'b1;
        s_req_node_idx = 4'(node);
        s_rsp_ready    = 1'b1;
        @(negedge clk);
        s_req_valid = 1'b0;
        s_got_n     = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (s_rsp_valid && s_got_n < 8) begin
                s_got_idx[s_got_n] = s_next_node_idx;
                s_got_cnt[s_got_n] = s_next_node_counter;
                s_got_n++;
                if (s_next_node_counter <= 2'd1) done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL s_request_%0d: last beat not seen within budget", node);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; reload = 1'b0; load_valid = 1'b0; load_cmd = '0; load_src = '0; load_dst = '0;
        req_valid = 1'b0; req_node_idx = '0; rsp_ready = 1'b0;
        s_rst = 1'b1; s_reload = 1'b0; s_load_valid = 1'b0; s_load_cmd = '0; s_load_src = '0;
        s_load_dst = '0; s_req_valid = 1'b0; s_req_node_idx = '0; s_rsp_ready = 1'b0;

        vecs[0] = mk(3, 3, 7, 3, 8, 2, 2, 1);
        vecs[1] = mk(10, 2, 11, 2, 12, 1, 0, 0);
        vecs[2] = mk(20, 1, 100, 1, 0, 0, 0, 0);
        vecs[3] = mk(42, 1, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(1, 1, (CHK != 0) ? 2 : 6, 1, 0, 0, 0, 0);
        vecs[5] = mk(4, 1, 5, 1, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_load_ready", int'(load_ready), 1);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_next_idx", int'(next_node_idx), 0);
        check("rst_next_cnt", int'(next_node_counter), 0);
        check("rst_errs", int'({err_overflow, err_fanout, err_order}), 0);
        rst   = 1'b0;
        s_rst = 1'b0;
        @(negedge clk);

        load(CMD_EDGE, 3, 7);
        load(CMD_EDGE, 3, 8);
        load(CMD_EDGE, 3, 2);
        load(CMD_EDGE, 10, 11);
        load(CMD_EDGE, 10, 12);
        load(CMD_EDGE, 20, 100);
        load(CMD_EDGE, 1, 2);
        load(CMD_EDGE, 4, 5);
        load(CMD_EDGE, 1, 6);
        check("err_order", int'(err_order), CHK);
        check("err_fanout_clean", int'(err_fanout), 0);
        check("err_overflow_clean", int'(err_overflow), 0);
        load(CMD_SET_START, 0, 5);
        load(CMD_SET_END, 0, 9);
        check("load_ready_pre_done", int'(load_ready), 1);
        load(CMD_DONE, 0, 0);

        // Start/end presentation, start held one cycle without rsp_ready
        check("start_valid", int'(rsp_valid), 1);
        check("start_idx", int'(next_node_idx), 5);
        check("start_cnt", int'(next_node_counter), 1);
        check("start_load_ready", int'(load_ready), 0);
        @(negedge clk);
        check("start_held_idx", int'(next_node_idx), 5);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("end_idx", int'(next_node_idx), 9);
        check("end_cnt", int'(next_node_counter), 1);
        check("end_req_ready", int'(req_ready), 0);
        @(negedge clk);
        check("idle_req_ready", int'(req_ready), 1);
        check("idle_rsp_valid", int'(rsp_valid), 0);

        // First-beat latency and back-to-back beats
        req_valid = 1'b1; req_node_idx = 10'd3; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("t1_rsp_valid", int'(rsp_valid), 0);
        check("t1_req_ready", int'(req_ready), 0);
        @(negedge clk);
        check("t2_rsp_valid", int'(rsp_valid), 1);
        check("t2_idx", int'(next_node_idx), 7);
        check("t2_cnt", int'(next_node_counter), 3);
        @(negedge clk);
        check("t3_idx", int'(next_node_idx), 8);
        check("t3_cnt", int'(next_node_counter), 2);
        @(negedge clk);
        check("t4_idx", int'(next_node_idx), 2);
        check("t4_cnt", int'(next_node_counter), 1);
        @(negedge clk);
        check("t5_req_ready", int'(req_ready), 1);
        check("t5_rsp_valid", int'(rsp_valid), 0);

        for (int v = 0; v < 6; v++) begin
            request(int'(vecs[v].node));
            check($sformatf("beats_node%0d", vecs[v].node), got_n, int'(vecs[v].n));
            for (int b = 0; b < 3; b++) begin
                if (b < int'(vecs[v].n) && b < got_n) begin
                    check($sformatf("idx_node%0d_beat%0d", vecs[v].node, b),
                          int'(got_idx[b]), int'(vecs[v].idx[b]));
                    check($sformatf("cnt_node%0d_beat%0d", vecs[v].node, b),
                          int'(got_cnt[b]), int'(vecs[v].cnt[b]));
                end
            end
        end

        // Backpressure: stall 4 cycles on the second beat
        req_valid = 1'b1; req_node_idx = 10'd3; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_first_idx", int'(next_node_idx), 7);
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_hold%0d_valid", i), int'(rsp_valid), 1);
            check($sformatf("bp_hold%0d_idx", i), int'(next_node_idx), 8);
            check($sformatf("bp_hold%0d_cnt", i), int'(next_node_counter), 2);
            @(negedge clk);
        end
        check("bp_after_idx", int'(next_node_idx), 8);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_last_idx", int'(next_node_idx), 2);
        check("bp_last_cnt", int'(next_node_counter), 1);
        @(negedge clk);
        check("bp_idle", int'(req_ready), 1);

        // Reload clears seen bits; start/end registers are kept
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_load_ready", int'(load_ready), 1);
        check("reload_req_ready", int'(req_ready), 0);
        check("reload_rsp_valid", int'(rsp_valid), 0);
        rsp_ready = 1'b1;
        load(CMD_DONE, 0, 0);
        check("reload_start_idx", int'(next_node_idx), 5);
        @(negedge clk);
        check("reload_end_idx", int'(next_node_idx), 9);
        @(negedge clk);
        request(3);
        check("reload_beats", got_n, 1);
        check("reload_idx", int'(got_idx[0]), 0);
        check("reload_cnt", int'(got_cnt[0]), 0);

        // Small instance: fan-out limit at 4 edges from one node
        s_load(CMD_EDGE, 0, 1);
        s_load(CMD_EDGE, 0, 2);
        s_load(CMD_EDGE, 0, 3);
        check("s_fanout_before", int'(s_err_fanout), 0);
        s_load(CMD_EDGE, 0, 4);
        check("s_fanout_4th", int'(s_err_fanout), CHK);
        check("s_overflow_a", int'(s_err_overflow), 0);
        s_load(CMD_DONE, 0, 0);
        s_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("s_idle_a", int'(s_req_ready), 1);
`ifdef EDGE_SERVER_ERR_CHECK_EN
        s_request(0);
        check("s_fan_beats", s_got_n, 3);
        check("s_fan_b0", int'({s_got_idx[0], s_got_cnt[0]}), int'({4'd1, 2'd3}));
        check("s_fan_b1", int'({s_got_idx[1], s_got_cnt[1]}), int'({4'd2, 2'd2}));
        check("s_fan_b2", int'({s_got_idx[2], s_got_cnt[2]}), int'({4'd3, 2'd1}));
`endif

        // Reset mid-stream
        s_rsp_ready = 1'b0;
        s_req_valid = 1'b1; s_req_node_idx = 4'd0;
        @(negedge clk);
        s_req_valid = 1'b0;
        @(negedge clk);
        check("s_stream_valid", int'(s_rsp_valid), 1);
        s_rst = 1'b1;
        #1;
        check("s_rst_rsp_valid", int'(s_rsp_valid), 0);
        check("s_rst_load_ready", int'(s_load_ready), 1);
        @(negedge clk);
        s_rst = 1'b0;
        check("s_rst_err_fanout", int'(s_err_fanout), 0);

        // Small instance: overflow on the 5th edge
        s_load(CMD_EDGE, 0, 5);
        s_load(CMD_EDGE, 1, 6);
        s_load(CMD_EDGE, 2, 7);
        s_load(CMD_EDGE, 3, 8);
        check("s_overflow_before", int'(s_err_overflow), 0);
        s_load(CMD_EDGE, 4, 9);
        check("s_overflow_5th", int'(s_err_overflow), CHK);
        s_load(CMD_DONE, 0, 0);
        s_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("s_idle_b", int'(s_req_ready), 1);
        s_request(3);
        check("s_n3_beats", s_got_n, 1);
        check("s_n3_beat", int'({s_got_idx[0], s_got_cnt[0]}), int'({4'd8, 2'd1}));
        s_request(0);
        check("s_n0_beats", s_got_n, 1);
        check("s_n0_idx", int'(s_got_idx[0]), (CHK != 0) ? 5 : 9);
        check("s_n0_cnt", int'(s_got_cnt[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
